ext_panel_in: RTL and testbench

EXT_PANEL_IN -- requirements
Module: ext_panel_in

---
 rtl/ext_panel_in.sv | 178 +++++++++++++++++
 tb/tb_ext_panel_in.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_panel_in.sv
// ext_panel_in
//   Front-end conditioning for the external panel inputs. Four toggle switches
//   and four active-low pushbuttons are synchronized into the clock domain and
//   debounced. Each button also runs a small press/auto-repeat machine that
//   emits single-cycle pulses.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   reset      : asynchronous, active-high reset
//   sw_in      : raw switches, active-high, asynchronous to clk
//   btn_n_in   : raw pushbuttons, active-low, asynchronous to clk
//   rpt_en     : auto-repeat enable (synchronous)
//   switches   : debounced switch levels (bit 0 = power, bits 3:1 = LED select)
//   btn_level  : debounced button levels, 1 = pressed
//   btn_press  : one-cycle press / repeat pulses per button
//   ext        : status byte {btn_level, switches}
module ext_panel_in #(
  parameter int DB_CYCLES   = 50000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int RPT_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_in,
  input  logic [3:0] btn_n_in,
  input  logic       rpt_en,
  output logic [3:0] switches,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [7:0] ext
);

  localparam int DBW  = $clog2(DB_CYCLES + 1);
  localparam int HMAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_TC  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]  RPT_LAST = HW'(RPT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } btnState_t;

  // Channels 3:0 are switches, 7:4 are buttons inverted to active-high.
  logic [7:0] w_raw;
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic [7:0] w_level;
  logic [7:0] w_levelNext;

  assign w_raw = {~btn_n_in, sw_in};

  // Two-flop synchronizer for every channel before anything else sees it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar ch = 0; ch < 8; ch++) begin : g_db
    logic           r_lvl;
    logic [DBW-1:0] r_dbCnt;
    logic           w_mismatch;
    logic           w_dbDone;

    // The level flips on the edge where the mismatch run would hit DB_CYCLES.
    assign w_mismatch      = r_sync2[ch] ^ r_lvl;
    assign w_dbDone        = w_mismatch && (r_dbCnt == DB_LAST);
    assign w_levelNext[ch] = w_dbDone ? ~r_lvl : r_lvl;
    assign w_level[ch]     = r_lvl;

    // Any agreeing cycle restarts the run, so short glitches never land.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_lvl   <= 1'b0;
        r_dbCnt <= '0;
      end else begin
        r_lvl <= w_levelNext[ch];
        if (!w_mismatch || w_dbDone) begin
          r_dbCnt <= '0;
        end else begin
          r_dbCnt <= r_dbCnt + DBW'(1);
        end
      end
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_btn
    btnState_t       r_state;
    btnState_t       w_stateNext;
    logic [HW-1:0]   r_cnt;
    logic [HW-1:0]   w_cntNext;
    logic            r_press;
    logic            w_pressNext;
    logic            w_down;
    logic            w_release;

    // Release looks at the level being written this edge, so a release that
    // lands together with a terminal count wins and suppresses the pulse.
    assign w_down       = w_level[4 + b];
    assign w_release    = ~w_levelNext[4 + b];
    assign btn_press[b] = r_press;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_press <= 1'b0;
      end else begin
        r_state <= w_stateNext;
        r_cnt   <= w_cntNext;
        r_press <= w_pressNext;
      end
    end

    // HELD counts up to HOLD_CYCLES and saturates there while repeat is off.
    // REPEAT fires on the cycle the counter would reach RPT_CYCLES so that
    // repeat pulses are spaced exactly RPT_CYCLES apart.
    always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_pressNext = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_down) begin
            w_pressNext = 1'b1;
            w_cntNext   = '0;
            w_stateNext = HELD;
          end
        end
        HELD: begin
          if (w_release) begin
            w_cntNext   = '0;
            w_stateNext = IDLE;
          end else if (r_cnt == HOLD_TC) begin
            if (rpt_en) begin
              w_pressNext = 1'b1;
              w_cntNext   = '0;
              w_stateNext = REPEAT;
            end
          end else begin
            w_cntNext = r_cnt + HW'(1);
          end
        end
        REPEAT: begin
          if (w_release) begin
            w_cntNext   = '0;
            w_stateNext = IDLE;
          end else if (!rpt_en) begin
            w_cntNext   = HOLD_TC;
            w_stateNext = HELD;
          end else if (r_cnt == RPT_LAST) begin
            w_pressNext = 1'b1;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt + HW'(1);
          end
        end
        default: begin
          w_cntNext   = '0;
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  assign switches  = w_level[3:0];
  assign btn_level = w_level[7:4];
  assign ext       = {btn_level, switches};

endmodule

// File: tb/tb_ext_panel_in.sv
// tb_ext_panel_in
//   Bench for ext_panel_in with short debounce/hold/repeat times. A directed
//   table walks through debounce latency, glitch rejection, press, hold,
//   repeat, release-on-terminal-count and repeat-disable; a hand sequence
//   covers reset in the middle of a repeat; then random input activity is
//   compared every cycle against a deadline-based reference model.
module tb_ext_panel_in;

  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int RPT  = 3;

  localparam int M_IDLE   = 0;
  localparam int M_HELD   = 1;
  localparam int M_REPEAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_in;
  logic [3:0] btn_n_in;
  logic       rpt_en;
  logic [3:0] switches;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [7:0] ext;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    int         edgeNo;
    logic [3:0] sw;
    logic [3:0] btnN;
    logic       rpt;
    logic [3:0] expSw;
    logic [3:0] expLvl;
    logic [3:0] expPress;
  } vec_t;

  vec_t vecs [23];

  // Reference model state: raw sample history, debounced levels, and per
  // button a mode plus the edge number at which the next pulse is due.
  logic [7:0] mh [DB + 2];
  logic [7:0] mLvl;
  logic [3:0] mPress;
  int         mMode [4];
  int         mDue  [4];
  int         mT;

  logic [3:0] rSw;
  logic [3:0] rBtn;
  logic       rRpt;

  always #5 clk = ~clk;

  ext_panel_in #(
    .DB_CYCLES  (DB),
    .HOLD_CYCLES(HOLD),
    .RPT_CYCLES (RPT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_in    (sw_in),
    .btn_n_in (btn_n_in),
    .rpt_en   (rpt_en),
    .switches (switches),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .ext      (ext)
  );

  function automatic logic [31:0] expBundle(input logic [3:0] sw, input logic [3:0] lvl,
                                            input logic [3:0] press);
    return {12'd0, sw, lvl, press, lvl, sw};
  endfunction

  function automatic logic [31:0] actBundle();
    return {12'd0, switches, btn_level, btn_press, ext};
  endfunction

  task automatic applyStimulus(input logic [3:0] sw, input logic [3:0] btnN, input logic rpt);
    sw_in    = sw;
    btn_n_in = btnN;
    rpt_en   = rpt;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h (sw,lvl,press,ext)", name, act[19:0], exp[19:0]);
    end
  endtask

  function automatic void modelReset();
    for (int k = 0; k < DB + 2; k++) mh[k] = '0;
    mLvl   = '0;
    mPress = '0;
    mT     = 0;
    for (int b = 0; b < 4; b++) begin
      mMode[b] = M_IDLE;
      mDue[b]  = 0;
    end
  endfunction

  // One clock edge of the reference model. A channel's level flips once the
  // last DB samples seen by the debouncer (raw delayed by two edges) all
  // disagree with it. Buttons pulse against deadlines measured in edges.
  function automatic void modelStep(input logic [3:0] sw, input logic [3:0] btnN, input logic rpt);
    logic [7:0] old;
    logic       flip;
    mT++;
    for (int k = DB + 1; k > 0; k--) mh[k] = mh[k - 1];
    mh[0] = {~btnN, sw};
    old = mLvl;
    for (int ch = 0; ch < 8; ch++) begin
      flip = 1'b1;
      for (int k = 2; k <= DB + 1; k++) begin
        if (mh[k][ch] == old[ch]) flip = 1'b0;
      end
      if (flip) mLvl[ch] = ~old[ch];
    end
    for (int b = 0; b < 4; b++) begin
      mPress[b] = 1'b0;
      if (mMode[b] == M_IDLE) begin
        if (old[4 + b]) begin
          mPress[b] = 1'b1;
          mMode[b]  = M_HELD;
          mDue[b]   = mT + HOLD + 1;
        end
      end else if (!mLvl[4 + b]) begin
        mMode[b] = M_IDLE;
      end else if (mMode[b] == M_HELD) begin
        if (rpt && mT >= mDue[b]) begin
          mPress[b] = 1'b1;
          mMode[b]  = M_REPEAT;
          mDue[b]   = mT + RPT;
        end
      end else if (!rpt) begin
        mMode[b] = M_HELD;
        mDue[b]  = mT;
      end else if (mT == mDue[b]) begin
        mPress[b] = 1'b1;
        mDue[b]   = mT + RPT;
      end
    end
  endfunction

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_state", actBundle(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    int curEdge;
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    modelReset();

    vecs[0]  = '{5,  4'b0001, 4'b1101, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{6,  4'b0001, 4'b1101, 1'b1, 4'b0001, 4'b0010, 4'b0000};
    vecs[2]  = '{7,  4'b0001, 4'b1101, 1'b1, 4'b0001, 4'b0010, 4'b0010};
    vecs[3]  = '{8,  4'b0001, 4'b1101, 1'b1, 4'b0001, 4'b0010, 4'b0000};
    vecs[4]  = '{17, 4'b0001, 4'b1101, 1'b1, 4'b0001, 4'b0010, 4'b0000};
    vecs[5]  = '{18, 4'b0001, 4'b1101, 1'b1, 4'b0001, 4'b0010, 4'b0010};
    vecs[6]  = '{19, 4'b0001, 4'b1101, 1'b1, 4'b0001, 4'b0010, 4'b0000};
    vecs[7]  = '{21, 4'b0001, 4'b1101, 1'b1, 4'b0001, 4'b0010, 4'b0010};
    vecs[8]  = '{24, 4'b0001, 4'b1101, 1'b1, 4'b0001, 4'b0010, 4'b0010};
    vecs[9]  = '{25, 4'b0001, 4'b1111, 1'b1, 4'b0001, 4'b0010, 4'b0000};
    vecs[10] = '{27, 4'b0001, 4'b1111, 1'b1, 4'b0001, 4'b0010, 4'b0010};
    vecs[11] = '{29, 4'b0001, 4'b1111, 1'b1, 4'b0001, 4'b0010, 4'b0000};
    vecs[12] = '{30, 4'b0001, 4'b1111, 1'b1, 4'b0001, 4'b0000, 4'b0000};
    vecs[13] = '{31, 4'b0001, 4'b1111, 1'b1, 4'b0001, 4'b0000, 4'b0000};
    vecs[14] = '{34, 4'b0101, 4'b1111, 1'b1, 4'b0001, 4'b0000, 4'b0000};
    vecs[15] = '{40, 4'b0001, 4'b1111, 1'b1, 4'b0001, 4'b0000, 4'b0000};
    vecs[16] = '{46, 4'b0001, 4'b1101, 1'b0, 4'b0001, 4'b0010, 4'b0000};
    vecs[17] = '{47, 4'b0001, 4'b1101, 1'b0, 4'b0001, 4'b0010, 4'b0010};
    vecs[18] = '{58, 4'b0001, 4'b1101, 1'b0, 4'b0001, 4'b0010, 4'b0000};
    vecs[19] = '{70, 4'b0001, 4'b1101, 1'b0, 4'b0001, 4'b0010, 4'b0000};
    vecs[20] = '{71, 4'b0001, 4'b1101, 1'b1, 4'b0001, 4'b0010, 4'b0010};
    vecs[21] = '{72, 4'b0001, 4'b1101, 1'b1, 4'b0001, 4'b0010, 4'b0000};
    vecs[22] = '{74, 4'b0001, 4'b1101, 1'b1, 4'b0001, 4'b0010, 4'b0010};

    // Directed table: inputs of a row are applied on every edge up to its edge.
    doReset();
    curEdge = 0;
    for (int i = 0; i < 23; i++) begin
      while (curEdge < vecs[i].edgeNo) begin
        applyStimulus(vecs[i].sw, vecs[i].btnN, vecs[i].rpt);
        @(posedge clk);
        curEdge++;
        #1;
      end
      checkOutput($sformatf("vec%0d_edge%0d", i, vecs[i].edgeNo), actBundle(),
                  expBundle(vecs[i].expSw, vecs[i].expLvl, vecs[i].expPress));
    end

    // Reset in the middle of a repeat with switch 3 and button 3 held through it.
    doReset();
    applyStimulus(4'b1000, 4'b0111, 1'b1);
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk);
      #1;
      if (e == 21) checkOutput("pre_rst_repeat21", actBundle(), expBundle(4'b1000, 4'b1000, 4'b1000));
      if (e == 22) checkOutput("pre_rst_repeat22", actBundle(), expBundle(4'b1000, 4'b1000, 4'b0000));
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_immediate", actBundle(), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rst_release_edge%0d", e), actBundle(),
                  expBundle((e >= 6) ? 4'b1000 : 4'b0000, (e >= 6) ? 4'b1000 : 4'b0000,
                            (e == 7) ? 4'b1000 : 4'b0000));
    end

    // Random activity against the reference model, with two async resets.
    doReset();
    rSw  = 4'b0000;
    rBtn = 4'b1111;
    rRpt = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 11) == 0) rSw[k] = ~rSw[k];
        if ($urandom_range(0, 29) == 0) rBtn[k] = ~rBtn[k];
      end
      if ($urandom_range(0, 39) == 0) rRpt = ~rRpt;
      applyStimulus(rSw, rBtn, rRpt);
      @(posedge clk);
      modelStep(sw_in, btn_n_in, rpt_en);
      #1;
      checkOutput($sformatf("rnd_cycle%0d", i), actBundle(), expBundle(mLvl[3:0], mLvl[7:4], mPress));
      if (i == 1000 || i == 2000) begin
        #2;
        reset = 1'b1;
        #1;
        checkOutput($sformatf("rnd_reset%0d", i), actBundle(), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
